uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, meaning payload bits per frame; fixed 8 in this release.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_read  input  1  acknowledge level from CPU PIO output bit; its rising edge consumes the held byte.
REQ-007 rx_valid  output  1  byte held and unread; drives CPU PIO input bit.
REQ-008 rx_data  output  8  held byte; stable while rx_valid=1.
REQ-009 frame_err  output  1  sticky: stop bit sampled low.
REQ-010 overrun  output  1  sticky: a frame completed while rx_valid=1.

Function
REQ-011 rxd and rx_read SHALL each pass a 2-flop synchronizer before any use.
REQ-012 rx_read edge detect SHALL produce a 1-cycle ack pulse on synchronized 0->1 transition; level-high SHALL NOT repeat ack.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: synchronized rxd=0 -> START, bit counter loaded with CLKS_PER_BIT/2 - 1.
REQ-015 START: at counter expiry, rxd=0 -> DATA (counter CLKS_PER_BIT-1, bit index 0); rxd=1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: at each expiry, sample rxd into shift register bit index (LSB first), reload counter; after index 7 -> STOP.
REQ-017 STOP: at expiry, rxd=1 -> frame accepted, IDLE; rxd=0 -> frame_err=1, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until synchronized rxd=1, then IDLE.
REQ-019 Accepted frame with rx_valid=0: rx_data loaded, rx_valid=1 on the next clk edge after stop-bit sample.
REQ-020 Accepted frame with rx_valid=1 and no ack same cycle: overrun=1, new byte dropped, rx_data unchanged.
REQ-021 Accepted frame and ack same cycle: new byte loaded, rx_valid stays 1, overrun unchanged.
REQ-022 Ack pulse SHALL clear rx_valid, frame_err, overrun on next clk edge (3 clks after raw rx_read rise).
REQ-023 Ack with rx_valid=0 SHALL only clear sticky flags.
REQ-024 Counter width SHALL be clog2(CLKS_PER_BIT); no wrap beyond reload value.

Reset
REQ-025 reset_n low SHALL asynchronously force FSM=IDLE, counters=0, synchronizer flops=1 (rxd) / 0 (rx_read), rx_valid=0, rx_data=0x00, frame_err=0, overrun=0.
REQ-026 Reset mid-frame SHALL discard partial byte; after release, reception restarts only on a new falling edge.
REQ-027 rx_read held high through reset release SHALL NOT generate an ack.

Structure
REQ-028 Package uart_pkg SHALL hold FSM state encodings and default CLKS_PER_BIT/DATA_BITS constants.
REQ-029 Sub-module sync_2ff (1-bit, reset-value parameter) SHALL implement REQ-011, instantiated twice.

Verification (bench CLKS_PER_BIT=16)
REQ-030 Send 0xA5 valid frame -> rx_valid=1, rx_data=0xA5 one clk after stop mid-sample; frame_err=overrun=0.
REQ-031 Pulse rxd low 4 clks in IDLE -> FSM returns IDLE, rx_valid=0, no flags.
REQ-032 Send 0x3C with stop bit low -> frame_err=1, rx_valid=0; next valid 0x55 received normally after line high.
REQ-033 Send 0x11 then 0x22 without ack -> rx_data=0x11, overrun=1; rx_read rise -> all three cleared 3 clks later.
REQ-034 Raise rx_read on the cycle second frame 0x77 completes -> rx_data=0x77, rx_valid=1, overrun=0.
REQ-035 Assert reset_n low during DATA bit 4 of 0xFF -> all outputs reset; rx_valid stays 0 after release until next frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive path.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 434;
   localparam int unsigned DATA_BITS_DEF    = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-byte holding register, level-edge ack and sticky error flags.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rxd,
   input  logic                 rx_read,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = $clog2(DATA_BITS);
   localparam logic [CntW-1:0] HalfReload = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullReload = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0] LastIdx    = IdxW'(DATA_BITS - 1);

   logic rxd_s, rd_s;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync_rxd (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rxd),
      .q_o     (rxd_s)
   );

   sync_2ff #(.RESET_VAL(1'b0)) u_sync_read (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rx_read),
      .q_o     (rd_s)
   );

   // Ack edge detection is held off until the synchronizer and previous-value flop
   // carry real samples, so a level already high at reset release is not an edge.
   logic [1:0] warm_q, warm_d;
   logic       rd_prev_q;
   logic       ack;

   always_comb begin
      warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      ack    = (warm_q == 2'd3) && rd_s && !rd_prev_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_q    <= 2'd0;
         rd_prev_q <= 1'b0;
      end else begin
         warm_q    <= warm_d;
         rd_prev_q <= rd_s;
      end
   end

   rx_state_e            state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 accept, stop_bad;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      accept   = 1'b0;
      stop_bad = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxd_s) begin
               state_d = StStart;
               cnt_d   = HalfReload;
            end
         end
         StStart: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (!rxd_s) begin
               state_d = StData;
               cnt_d   = FullReload;
               idx_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StData: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               shift_d[idx_q] = rxd_s;
               cnt_d          = FullReload;
               if (idx_q == LastIdx) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         StStop: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (rxd_s) begin
               accept  = 1'b1;
               state_d = StIdle;
            end else begin
               stop_bad = 1'b1;
               state_d  = StWaitHigh;
            end
         end
         StWaitHigh: begin
            if (rxd_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   logic                 valid_q, valid_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   // Ack clears first; a frame finishing in the same cycle then lands in the freed slot.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      if (ack) begin
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
      if (accept) begin
         if (!valid_q || ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
      if (stop_bad) begin
         ferr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_valid  = valid_q;
   assign rx_data   = data_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized and directed bench for uart_rx_core against a frame-level behavioural model.
module tb_uart_rx_core;

   localparam int unsigned CLKS = 16;
   localparam int FRAME_EDGES   = 10 * CLKS + 12;
   // Start seen after 2 sync edges + 1 detect edge, half a bit to centre, then 9 full bits.
   localparam int EXP_RISE      = 3 + CLKS / 2 + 9 * CLKS;
   localparam int NONE          = -100;

   logic       clk = 1'b0;
   logic       reset_n, rxd, rx_read;
   logic       rx_valid, frame_err, overrun;
   logic [7:0] rx_data;

   int checks = 0;
   int errors = 0;

   logic       m_valid, m_ferr, m_ovr;
   logic [7:0] m_data;

   always #5 clk = ~clk;

   uart_rx_core #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rxd       (rxd),
      .rx_read   (rx_read),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   function automatic void model_reset();
      m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
   endfunction

   function automatic void model_ack();
      m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit ack_now);
      logic was_valid;
      was_valid = m_valid;
      if (ack_now) model_ack();
      if (!stop_ok) m_ferr = 1'b1;
      else if (!was_valid || ack_now) begin
         m_data  = b;
         m_valid = 1'b1;
      end else m_ovr = 1'b1;
   endfunction

   // Drives one frame starting after edge 0; optional rx_read rise and reset pulse at given edges.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int ack_edge,
                             input int rst_edge, output int rise_edge, output logic [10:0] snap);
      logic prev_v;
      int   bp;
      rise_edge = -1;
      snap      = '0;
      prev_v    = rx_valid;
      for (int n = 0; n < FRAME_EDGES; n++) begin
         @(posedge clk); #1;
         if (rx_valid && !prev_v && rise_edge < 0) rise_edge = n;
         prev_v = rx_valid;
         if (n == rst_edge + 2) snap = {rx_valid, frame_err, overrun, rx_data};
         if (n == rst_edge) reset_n = 1'b0;
         if (n == rst_edge + 3) reset_n = 1'b1;
         if (n == ack_edge) rx_read = 1'b1;
         bp = n / CLKS;
         if (bp == 0) rxd = 1'b0;
         else if (bp <= 8) rxd = b[bp-1];
         else if (bp == 9) rxd = stop_ok;
         else rxd = 1'b1;
      end
   endtask

   task automatic do_ack();
      @(posedge clk); #1 rx_read = 1'b1;
      repeat (3) @(posedge clk);
      #1 model_ack();
      rx_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; rxd = 1'b1; rx_read = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_valid_frame();
      int rise; logic [10:0] snap;
      send_frame(8'hA5, 1'b1, NONE, NONE, rise, snap);
      model_frame(8'hA5, 1'b1, 1'b0);
      checks++;
      if (rise < EXP_RISE - 1 || rise > EXP_RISE + 1) begin
         errors++; $display("FAIL a5_latency got %0d want %0d+-1", rise, EXP_RISE);
      end
      checks++;
      if ({rx_valid, frame_err, overrun, rx_data} !== {m_valid, m_ferr, m_ovr, m_data}) begin
         errors++;
         $display("FAIL a5_frame got v%b fe%b ov%b %h want v%b fe%b ov%b %h",
                  rx_valid, frame_err, overrun, rx_data, m_valid, m_ferr, m_ovr, m_data);
      end
      do_ack();
      checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL a5_ack got %b want %b", rx_valid, m_valid); end
   endtask

   task automatic test_glitch();
      int rise; logic [10:0] snap; logic [7:0] b;
      @(posedge clk); #1 rxd = 1'b0;
      repeat (4) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if ({rx_valid, frame_err, overrun} !== 3'b000) begin
         errors++; $display("FAIL glitch got v%b fe%b ov%b want 000", rx_valid, frame_err, overrun);
      end
      b = 8'($urandom);
      send_frame(b, 1'b1, NONE, NONE, rise, snap);
      model_frame(b, 1'b1, 1'b0);
      checks++;
      if ({rx_valid, rx_data} !== {m_valid, m_data}) begin
         errors++; $display("FAIL glitch_next got v%b %h want v%b %h", rx_valid, rx_data, m_valid, m_data);
      end
      do_ack();
   endtask

   task automatic test_frame_error();
      int rise; logic [10:0] snap;
      send_frame(8'h3C, 1'b0, NONE, NONE, rise, snap);
      model_frame(8'h3C, 1'b0, 1'b0);
      checks++;
      if ({rx_valid, frame_err} !== {m_valid, m_ferr}) begin
         errors++; $display("FAIL ferr_3c got v%b fe%b want v%b fe%b", rx_valid, frame_err, m_valid, m_ferr);
      end
      send_frame(8'h55, 1'b1, NONE, NONE, rise, snap);
      model_frame(8'h55, 1'b1, 1'b0);
      checks++;
      if ({rx_valid, frame_err, overrun, rx_data} !== {m_valid, m_ferr, m_ovr, m_data}) begin
         errors++;
         $display("FAIL ferr_55 got v%b fe%b ov%b %h want v%b fe%b ov%b %h",
                  rx_valid, frame_err, overrun, rx_data, m_valid, m_ferr, m_ovr, m_data);
      end
      do_ack();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", frame_err); end
   endtask

   task automatic test_overrun();
      int rise; logic [10:0] snap;
      send_frame(8'h11, 1'b1, NONE, NONE, rise, snap);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, NONE, NONE, rise, snap);
      model_frame(8'h22, 1'b1, 1'b0);
      checks++;
      if ({rx_valid, overrun, rx_data} !== {m_valid, m_ovr, m_data}) begin
         errors++; $display("FAIL ovr_hold got v%b ov%b %h want v%b ov%b %h",
                            rx_valid, overrun, rx_data, m_valid, m_ovr, m_data);
      end
      @(posedge clk); #1 rx_read = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rx_valid, overrun} !== 2'b11) begin
         errors++; $display("FAIL ovr_ack_early got v%b ov%b want v1 ov1", rx_valid, overrun);
      end
      @(posedge clk); #1;
      model_ack();
      checks++;
      if ({rx_valid, frame_err, overrun} !== {m_valid, m_ferr, m_ovr}) begin
         errors++; $display("FAIL ovr_ack_clear got v%b fe%b ov%b want 000", rx_valid, frame_err, overrun);
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_level_hold got %b want 0", rx_valid); end
      rx_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_ack_same_cycle();
      int rise; logic [10:0] snap;
      send_frame(8'h66, 1'b1, NONE, NONE, rise, snap);
      model_frame(8'h66, 1'b1, 1'b0);
      // rx_read rises so its synchronized ack coincides with the stop-bit decision.
      send_frame(8'h77, 1'b1, EXP_RISE - 3, NONE, rise, snap);
      model_frame(8'h77, 1'b1, 1'b1);
      checks++;
      if ({rx_valid, overrun, rx_data} !== {m_valid, m_ovr, m_data}) begin
         errors++; $display("FAIL ack_same got v%b ov%b %h want v%b ov%b %h",
                            rx_valid, overrun, rx_data, m_valid, m_ovr, m_data);
      end
      rx_read = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({rx_valid, rx_data} !== {m_valid, m_data}) begin
         errors++; $display("FAIL ack_same_fall got v%b %h want v%b %h", rx_valid, rx_data, m_valid, m_data);
      end
   endtask

   task automatic test_reset_mid_frame();
      int rise; logic [10:0] snap;
      send_frame(8'hFF, 1'b1, NONE, 5 * CLKS + 8, rise, snap);
      model_reset();
      checks++;
      if (snap !== 11'd0) begin errors++; $display("FAIL rst_during got %h want 000", snap); end
      checks++;
      if ({rx_valid, frame_err, overrun, rx_data} !== {m_valid, m_ferr, m_ovr, m_data}) begin
         errors++; $display("FAIL rst_after got v%b fe%b ov%b %h want all zero",
                            rx_valid, frame_err, overrun, rx_data);
      end
      checks++;
      if (rise != -1) begin errors++; $display("FAIL rst_no_frame got rise %0d want -1", rise); end
   endtask

   task automatic test_read_high_reset();
      int rise; logic [10:0] snap; logic [7:0] b;
      reset_n = 1'b0;
      rx_read = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      b = 8'($urandom);
      send_frame(b, 1'b1, NONE, NONE, rise, snap);
      model_frame(b, 1'b1, 1'b0);
      checks++;
      if ({rx_valid, rx_data} !== {m_valid, m_data}) begin
         errors++; $display("FAIL read_high got v%b %h want v%b %h", rx_valid, rx_data, m_valid, m_data);
      end
      rx_read = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      do_ack();
   endtask

   task automatic test_random_stream();
      int rise; logic [10:0] snap; logic [7:0] b; bit ok;
      for (int i = 0; i < 10; i++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_frame(b, ok, NONE, NONE, rise, snap);
         model_frame(b, ok, 1'b0);
         checks++;
         if ({rx_valid, frame_err, overrun, rx_data} !== {m_valid, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL rand_%0d got v%b fe%b ov%b %h want v%b fe%b ov%b %h", i,
                     rx_valid, frame_err, overrun, rx_data, m_valid, m_ferr, m_ovr, m_data);
         end
         if ($urandom_range(0, 1) == 1) do_ack();
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_ack_same_cycle();
      test_reset_mid_frame();
      test_read_high_reset();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
